// File: rtl/i2s_rx_master_if.sv
// Pad and FIFO-side signal bundle for the I2S receive master.
// The master modport is the receiver; the slave modport is the pads/bus wrapper.
interface i2s_rx_master_if #(
    parameter int AW = 4
);
    logic          sck;
    logic          ws;
    logic          sdi;
    logic          fifo_rd;
    logic [31:0]   fifo_rdata;
    logic          fifo_rch;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_level;
    logic [AW:0]   fifo_threshold;
    logic          fifo_above;
    logic          overrun;
    logic          ovr_clr;

    modport master (
        output sck, ws, fifo_rdata, fifo_rch, fifo_empty, fifo_full,
               fifo_level, fifo_above, overrun,
        input  sdi, fifo_rd, fifo_threshold, ovr_clr
    );

    modport slave (
        input  sck, ws, fifo_rdata, fifo_rch, fifo_empty, fifo_full,
               fifo_level, fifo_above, overrun,
        output sdi, fifo_rd, fifo_threshold, ovr_clr
    );
endinterface

// File: rtl/i2s_rx_master.sv
// I2S receive master: generates SCK/WS, deserialises SDI (Philips or left-justified)
// and pushes channel-tagged, sign/zero-extended samples into a show-ahead FIFO.
module i2s_rx_master #(
    parameter int AW = 4,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [PW-1:0] prescaler_i,
    input  logic [4:0]    slot_size_i,
    input  logic [4:0]    sample_size_i,
    input  logic          mode_i,
    input  logic [1:0]    channels_i,
    input  logic          sign_ext_i,
    i2s_rx_master_if.master bus_io
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] LVL_FULL = {1'b1, {AW{1'b0}}};

    logic [PW-1:0] presc_q, presc_d;
    logic          sck_q, sck_d;
    logic          ws_q, ws_d;
    logic [4:0]    bit_ctr_q, bit_ctr_d;
    logic          rise_q, rise_d;
    logic          first_q, first_d;
    logic [31:0]   shift_q, shift_d;
    logic          push_q, push_d;
    logic [31:0]   push_word_q, push_word_d;
    logic          push_ch_q, push_ch_d;

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overrun_q, overrun_d;

    logic [4:0]    bit_pos;
    logic          bit_ch;
    logic          spill;
    logic          bit_keep;
    logic          chan_en;
    logic [31:0]   shifted;
    logic          sign_bit;
    logic [31:0]   fmt_word;

    logic          fifo_empty;
    logic          fifo_full;
    logic          rd_en;
    logic          wr_en;
    logic          ovr_set;

    // Slot ownership of the bit sampled at this rise; in Philips mode the bit at
    // bit_ctr 0 is the LSB of the slot that just ended.
    always_comb begin
        bit_pos = bit_ctr_q;
        bit_ch  = ws_q;
        if (!mode_i) begin
            if (bit_ctr_q == 5'd0) begin
                bit_pos = slot_size_i;
                bit_ch  = ~ws_q;
            end else begin
                bit_pos = bit_ctr_q - 5'd1;
            end
        end
    end

    assign spill    = !mode_i && (bit_ctr_q == 5'd0) && first_q;
    assign bit_keep = !spill && (bit_pos <= sample_size_i);
    assign chan_en  = bit_ch ? channels_i[0] : channels_i[1];
    assign shifted  = {shift_q[30:0], bus_io.sdi};
    assign sign_bit = shifted[sample_size_i];

    for (genvar gi = 0; gi < 32; gi++) begin : g_fmt
        assign fmt_word[gi] = (5'(gi) <= sample_size_i) ? shifted[gi]
                                                         : (sign_ext_i & sign_bit);
    end

    // SDI is sampled one clk after SCK is registered high, so the pin has settled.
    always_comb begin
        presc_d     = presc_q;
        sck_d       = sck_q;
        ws_d        = ws_q;
        bit_ctr_d   = bit_ctr_q;
        rise_d      = 1'b0;
        first_d     = first_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        push_ch_d   = push_ch_q;
        if (!en_i) begin
            presc_d   = prescaler_i;
            sck_d     = 1'b0;
            ws_d      = 1'b0;
            bit_ctr_d = 5'd0;
            first_d   = 1'b1;
            shift_d   = 32'd0;
        end else begin
            if (presc_q == '0) begin
                presc_d = prescaler_i;
                sck_d   = ~sck_q;
                rise_d  = ~sck_q;
                if (sck_q) begin
                    if (bit_ctr_q == slot_size_i) begin
                        bit_ctr_d = 5'd0;
                        ws_d      = ~ws_q;
                    end else begin
                        bit_ctr_d = bit_ctr_q + 5'd1;
                    end
                end
            end else begin
                presc_d = presc_q - 1'b1;
            end
            if (rise_q) begin
                first_d = 1'b0;
                if (bit_keep) begin
                    shift_d = shifted;
                    if (bit_pos == sample_size_i) begin
                        push_d      = chan_en;
                        push_word_d = fmt_word;
                        push_ch_d   = bit_ch;
                    end
                end
            end
        end
    end

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign rd_en      = bus_io.fifo_rd && !fifo_empty;
    assign wr_en      = push_q && (!fifo_full || rd_en);
    assign ovr_set    = push_q && fifo_full && !rd_en;

    always_comb begin
        wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d   = level_q;
        if (wr_en && !rd_en) begin
            level_d = level_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            level_d = level_q - 1'b1;
        end
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (bus_io.ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            sck_q       <= 1'b0;
            ws_q        <= 1'b0;
            bit_ctr_q   <= 5'd0;
            rise_q      <= 1'b0;
            first_q     <= 1'b1;
            shift_q     <= 32'd0;
            push_q      <= 1'b0;
            push_word_q <= 32'd0;
            push_ch_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sck_q       <= sck_d;
            ws_q        <= ws_d;
            bit_ctr_q   <= bit_ctr_d;
            rise_q      <= rise_d;
            first_q     <= first_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            push_ch_q   <= push_ch_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {push_ch_q, push_word_q};
        end
    end

    assign bus_io.sck        = sck_q;
    assign bus_io.ws         = ws_q;
    assign bus_io.fifo_rdata = mem[rd_ptr_q][31:0];
    assign bus_io.fifo_rch   = mem[rd_ptr_q][32];
    assign bus_io.fifo_empty = fifo_empty;
    assign bus_io.fifo_full  = fifo_full;
    assign bus_io.fifo_level = level_q;
    assign bus_io.fifo_above = (level_q > bus_io.fifo_threshold);
    assign bus_io.overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_rx_master.sv
// Directed bench for i2s_rx_master: a transmitter model follows the DUT's SCK/WS
// and drives SDI from per-channel slot words; each scenario checks FIFO output.
module tb_i2s_rx_master;
    localparam int AW = 2;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          en;
    logic [PW-1:0] prescaler;
    logic [4:0]    slot_size;
    logic [4:0]    sample_size;
    logic          mode;
    logic [1:0]    channels;
    logic          sign_ext;

    i2s_rx_master_if #(.AW(AW)) bus ();

    i2s_rx_master #(.AW(AW), .PW(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .prescaler_i (prescaler),
        .slot_size_i (slot_size),
        .sample_size_i(sample_size),
        .mode_i      (mode),
        .channels_i  (channels),
        .sign_ext_i  (sign_ext),
        .bus_io      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Transmitter: slot words are MSB-aligned to slot width; right words can come from a table.
    logic [31:0] tx_l = 32'd0;
    logic [31:0] tx_r = 32'd0;
    bit          use_tab = 1'b0;
    logic [31:0] r_tab [8] = '{32'h1111, 32'h2222, 32'h3333, 32'h4444,
                               32'h5555, 32'h6666, 32'h7777, 32'h8888};
    int   tx_idx = 0;
    int   tx_frame = 0;
    logic prev_sck = 1'b0;
    logic prev_ws = 1'b0;

    function automatic logic tx_bit();
        int          p;
        logic        ch;
        logic [31:0] w;
        if (mode) begin
            p = tx_idx; ch = bus.ws;
        end else if (tx_idx == 0) begin
            p = int'(slot_size); ch = ~bus.ws;
        end else begin
            p = tx_idx - 1; ch = bus.ws;
        end
        w = ch ? (use_tab ? r_tab[tx_frame % 8] : tx_r) : tx_l;
        return w[int'(slot_size) - p];
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst || !en) begin
            tx_idx = 0; tx_frame = 0; prev_sck = 1'b0; prev_ws = 1'b0;
        end else begin
            if (prev_sck && !bus.sck) begin
                if (bus.ws != prev_ws) begin
                    tx_idx = 0;
                    if (!bus.ws) tx_frame++;
                end else begin
                    tx_idx++;
                end
            end
            prev_sck = bus.sck;
            prev_ws  = bus.ws;
        end
        bus.sdi = tx_bit();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_level(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(bus.fifo_level) >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop();
        $display("pop: ch=%0d data=%h level=%0d", bus.fifo_rch, bus.fifo_rdata, bus.fifo_level);
        bus.fifo_rd = 1'b1;
        @(negedge clk);
        bus.fifo_rd = 1'b0;
    endtask

    task automatic flush();
        for (int i = 0; i < 8 && !bus.fifo_empty; i++) pop();
    endtask

    task automatic start(input logic m, input logic [4:0] sl, input logic [4:0] sa,
                         input logic [1:0] ch, input logic se);
        en = 1'b0;
        tick(1);
        mode = m; slot_size = sl; sample_size = sa; channels = ch; sign_ext = se;
        prescaler = 8'd1;
        tick(1);
        en = 1'b1;
    endtask

    task automatic stop();
        en = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; bus.fifo_rd = 1'b0; bus.ovr_clr = 1'b0; bus.fifo_threshold = '0;
        prescaler = 8'd1; slot_size = 5'd15; sample_size = 5'd15; mode = 1'b1;
        channels = 2'b11; sign_ext = 1'b0;
        tick(3);
        checks++; if (bus.sck !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b required 0", bus.sck); end
        checks++; if (bus.ws !== 1'b0) begin errors++; $display("FAIL rst_ws: got %b required 0", bus.ws); end
        checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b required 1", bus.fifo_empty); end
        checks++; if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b required 0", bus.fifo_full); end
        checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d required 0", bus.fifo_level); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b required 0", bus.overrun); end
        checks++; if (bus.fifo_above !== 1'b0) begin errors++; $display("FAIL rst_above: got %b required 0", bus.fifo_above); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_lj();
        int   elapsed;
        int   period;
        logic prev;
        logic empty63;
        bit   ok;
        tx_l = 32'hA5C3; tx_r = 32'h1234; use_tab = 1'b0;
        start(1'b1, 5'd15, 5'd15, 2'b11, 1'b0);
        tick(1);
        checks++; if (bus.sck !== 1'b0) begin errors++; $display("FAIL lj_sck_early: got %b required 0 after 1 clk", bus.sck); end
        tick(1);
        checks++; if (bus.sck !== 1'b1) begin errors++; $display("FAIL lj_first_rise: got %b required 1 after 2 clk", bus.sck); end
        elapsed = 2; period = 0; prev = bus.sck;
        for (int i = 0; i < 20; i++) begin
            tick(1); elapsed++; period++;
            if (bus.sck && !prev) break;
            prev = bus.sck;
        end
        checks++; if (period != 4) begin errors++; $display("FAIL lj_sck_period: got %0d clk required 4", period); end
        empty63 = 1'b0;
        for (int i = 0; i < 100 && bus.ws !== 1'b1; i++) begin
            tick(1); elapsed++;
            if (elapsed == 63) empty63 = bus.fifo_empty;
        end
        checks++; if (elapsed != 64) begin errors++; $display("FAIL lj_ws_rise: got clk %0d required 64", elapsed); end
        checks++; if (empty63 !== 1'b1) begin errors++; $display("FAIL lj_empty_63: got %b required 1", empty63); end
        checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL lj_level_64: got %0d required 1", bus.fifo_level); end
        for (int i = 0; i < 100 && bus.ws !== 1'b0; i++) begin
            tick(1); elapsed++;
        end
        checks++; if (elapsed != 128) begin errors++; $display("FAIL lj_ws_fall: got clk %0d required 128", elapsed); end
        for (int f = 0; f < 2; f++) begin
            wait_level(2, 200, ok);
            checks++; if (!ok) begin errors++; $display("FAIL lj_wait: level %0d required >= 2", bus.fifo_level); end
            checks++; if ({bus.fifo_rch, bus.fifo_rdata} !== {1'b0, 32'h0000A5C3}) begin
                errors++; $display("FAIL lj_left: got %b/%h required 0/0000a5c3", bus.fifo_rch, bus.fifo_rdata); end
            pop();
            checks++; if ({bus.fifo_rch, bus.fifo_rdata} !== {1'b1, 32'h00001234}) begin
                errors++; $display("FAIL lj_right: got %b/%h required 1/00001234", bus.fifo_rch, bus.fifo_rdata); end
            pop();
        end
        stop();
        flush();
    endtask

    task automatic test_i2s();
        bit ok;
        tx_l = 32'hA5C3; tx_r = 32'h1234; use_tab = 1'b0;
        start(1'b0, 5'd15, 5'd15, 2'b11, 1'b0);
        tick(20);
        checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL i2s_spill: got empty=%b required 1", bus.fifo_empty); end
        for (int f = 0; f < 2; f++) begin
            wait_level(2, 250, ok);
            checks++; if (!ok) begin errors++; $display("FAIL i2s_wait: level %0d required >= 2", bus.fifo_level); end
            checks++; if ({bus.fifo_rch, bus.fifo_rdata} !== {1'b0, 32'h0000A5C3}) begin
                errors++; $display("FAIL i2s_left: got %b/%h required 0/0000a5c3", bus.fifo_rch, bus.fifo_rdata); end
            pop();
            checks++; if ({bus.fifo_rch, bus.fifo_rdata} !== {1'b1, 32'h00001234}) begin
                errors++; $display("FAIL i2s_right: got %b/%h required 1/00001234", bus.fifo_rch, bus.fifo_rdata); end
            pop();
        end
        stop();
        flush();
    endtask

    task automatic test_sign_ext();
        logic        se_tab  [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] tx_tab  [3] = '{32'h8AB0, 32'h8AB0, 32'h7AB0};
        logic [31:0] exp_tab [3] = '{32'hFFFFF8AB, 32'h000008AB, 32'h000007AB};
        bit ok;
        for (int v = 0; v < 3; v++) begin
            tx_l = tx_tab[v]; tx_r = 32'h1230; use_tab = 1'b0;
            start(1'b1, 5'd15, 5'd11, 2'b10, se_tab[v]);
            wait_level(1, 200, ok);
            checks++; if (!ok) begin errors++; $display("FAIL sext_wait[%0d]: level %0d required >= 1", v, bus.fifo_level); end
            checks++; if ({bus.fifo_rch, bus.fifo_rdata} !== {1'b0, exp_tab[v]}) begin
                errors++; $display("FAIL sext[%0d]: got %b/%h required 0/%h", v, bus.fifo_rch, bus.fifo_rdata, exp_tab[v]); end
            stop();
            flush();
        end
    endtask

    task automatic test_overrun();
        bit ok;
        use_tab = 1'b1;
        start(1'b1, 5'd15, 5'd15, 2'b01, 1'b0);
        wait_level(4, 700, ok);
        checks++; if (!ok || bus.fifo_full !== 1'b1) begin errors++; $display("FAIL ovr_full: full=%b level=%0d required full=1", bus.fifo_full, bus.fifo_level); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b required 0", bus.overrun); end
        for (int i = 0; i < 200 && !bus.overrun; i++) tick(1);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b required 1", bus.overrun); end
        checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL ovr_level: got %0d required 4", bus.fifo_level); end
        stop();
        bus.ovr_clr = 1'b1; tick(1); bus.ovr_clr = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b required 0", bus.overrun); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus.fifo_rch, bus.fifo_rdata} !== {1'b1, r_tab[i]}) begin
                errors++; $display("FAIL ovr_order[%0d]: got %b/%h required 1/%h", i, bus.fifo_rch, bus.fifo_rdata, r_tab[i]); end
            pop();
        end
        checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL ovr_drained: empty=%b required 1", bus.fifo_empty); end
        pop();
        checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL ovr_pop_empty: level %0d required 0", bus.fifo_level); end
        use_tab = 1'b0;
    endtask

    task automatic test_threshold();
        bit ok;
        use_tab = 1'b1;
        bus.fifo_threshold = 3'd2;
        start(1'b1, 5'd15, 5'd15, 2'b01, 1'b0);
        wait_level(2, 400, ok);
        checks++; if (!ok || bus.fifo_above !== 1'b0) begin errors++; $display("FAIL thr_at2: above=%b level=%0d required 0", bus.fifo_above, bus.fifo_level); end
        wait_level(3, 200, ok);
        checks++; if (!ok || bus.fifo_above !== 1'b1) begin errors++; $display("FAIL thr_at3: above=%b level=%0d required 1", bus.fifo_above, bus.fifo_level); end
        stop();
        pop();
        checks++; if (bus.fifo_level !== 3'd2 || bus.fifo_above !== 1'b0) begin
            errors++; $display("FAIL thr_back2: above=%b level=%0d required 0 at level 2", bus.fifo_above, bus.fifo_level); end
        flush();
        bus.fifo_threshold = '0;
        use_tab = 1'b0;
    endtask

    task automatic test_en_drop();
        bit ok;
        tx_l = 32'hA5C3; tx_r = 32'h1234;
        start(1'b1, 5'd15, 5'd15, 2'b11, 1'b0);
        wait_level(1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_wait: level %0d required >= 1", bus.fifo_level); end
        for (int i = 0; i < 40 && !(bus.ws && bus.sck); i++) tick(1);
        en = 1'b0;
        tick(1);
        checks++; if (bus.sck !== 1'b0 || bus.ws !== 1'b0) begin errors++; $display("FAIL endrop_bus: sck=%b ws=%b required 0/0", bus.sck, bus.ws); end
        checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL endrop_level: got %0d required 1", bus.fifo_level); end
        tick(200);
        checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL endrop_nopush: got %0d required 1", bus.fifo_level); end
        flush();
    endtask

    task automatic test_rst_mid();
        tx_l = 32'hA5C3; tx_r = 32'h1234;
        start(1'b1, 5'd15, 5'd15, 2'b11, 1'b0);
        for (int i = 0; i < 700 && !bus.overrun; i++) tick(1);
        tick(7);
        checks++; if (bus.overrun !== 1'b1 || bus.fifo_level !== 3'd4) begin
            errors++; $display("FAIL rstmid_pre: overrun=%b level=%0d required 1/4", bus.overrun, bus.fifo_level); end
        rst = 1'b1;
        #1;
        checks++; if (bus.fifo_level !== 3'd0 || bus.fifo_empty !== 1'b1) begin
            errors++; $display("FAIL rstmid_fifo: level=%0d empty=%b required 0/1", bus.fifo_level, bus.fifo_empty); end
        checks++; if (bus.overrun !== 1'b0 || bus.sck !== 1'b0 || bus.ws !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: overrun=%b sck=%b ws=%b required 0/0/0", bus.overrun, bus.sck, bus.ws); end
        en = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_lj();
        test_i2s();
        test_sign_ext();
        test_overrun();
        test_threshold();
        test_en_drop();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
